// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: opcodes, FSM states,
// funct3 access-size codes and the byte-enable generator.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    eOpNone  = 2'd0,
    eOpLoad  = 2'd1,
    eOpStore = 2'd2
  } tOpcode;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    WB      = 2'd3
  } tLsuState;

  typedef logic [2:0] tMemSize;

  localparam tMemSize cF3Lb  = 3'b000;
  localparam tMemSize cF3Lh  = 3'b001;
  localparam tMemSize cF3Lw  = 3'b010;
  localparam tMemSize cF3Lbu = 3'b100;
  localparam tMemSize cF3Lhu = 3'b101;

  // size is funct3[1:0]: 00 byte, 01 halfword, otherwise word
  function automatic logic [3:0] fByteEn(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lsb;
      2'b01:   be = 4'b0011 << addr_lsb;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Issue-side, data-memory and write-back signals of lsu_ctrl bundled as one interface.
// oTimeout exists only when LSU_TIMEOUT_EN is defined.
interface lsu_ctrl_if
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            iValid;
  logic            oReady;
  tOpcode          iOpcode;
  tMemSize         iFunct3;
  logic [XLEN-1:0] iAddr;
  logic [XLEN-1:0] iStoreData;
  logic [4:0]      iRdAddr;

  logic            oMemReq;
  logic            iMemGnt;
  logic            oMemWe;
  logic [XLEN-1:0] oMemAddr;
  logic [3:0]      oMemBe;
  logic [XLEN-1:0] oMemWData;
  logic            iMemRValid;
  logic [XLEN-1:0] iMemRData;

  logic            oWbValid;
  logic [4:0]      oWbRdAddr;
  logic [XLEN-1:0] oWbData;
  logic            oMisalign;
  logic            oBusy;
`ifdef LSU_TIMEOUT_EN
  logic            oTimeout;
`endif

  modport slave (
    input  iValid, iOpcode, iFunct3, iAddr, iStoreData, iRdAddr,
    input  iMemGnt, iMemRValid, iMemRData,
    output oReady, oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData,
    output oWbValid, oWbRdAddr, oWbData, oMisalign, oBusy
`ifdef LSU_TIMEOUT_EN
    , output oTimeout
`endif
  );

  modport master (
    output iValid, iOpcode, iFunct3, iAddr, iStoreData, iRdAddr,
    output iMemGnt, iMemRValid, iMemRData,
    input  oReady, oMemReq, oMemWe, oMemAddr, oMemBe, oMemWData,
    input  oWbValid, oWbRdAddr, oWbData, oMisalign, oBusy
`ifdef LSU_TIMEOUT_EN
    , input oTimeout
`endif
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the byte/halfword lane addressed by the
// low address bits and sign- or zero-extends it to XLEN.
module lsu_load_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] iWord,
  input  tMemSize         iFunct3,
  input  logic [1:0]      iAddrLsb,
  output logic [XLEN-1:0] oData
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (iAddrLsb)
      2'd0:    byte_sel = iWord[7:0];
      2'd1:    byte_sel = iWord[15:8];
      2'd2:    byte_sel = iWord[23:16];
      default: byte_sel = iWord[31:24];
    endcase
    half_sel = iAddrLsb[1] ? iWord[31:16] : iWord[15:0];

    case (iFunct3)
      cF3Lb:   oData = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      cF3Lh:   oData = {{(XLEN-16){half_sel[15]}}, half_sel};
      cF3Lbu:  oData = {{(XLEN-8){1'b0}}, byte_sel};
      cF3Lhu:  oData = {{(XLEN-16){1'b0}}, half_sel};
      default: oData = iWord;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory op at a time over a req/gnt/rvalid port.
// Define LSU_TIMEOUT_EN to add the read-response watchdog and oTimeout.
//
// state   | meaning
// IDLE    | oReady high, waiting for a load/store
// REQ     | oMemReq held with stable address/be/data until iMemGnt
// WAIT_RD | load granted, waiting for iMemRValid
// WB      | one-cycle write-back pulse (suppressed for rd = 0)
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic       iClk,
  input  logic       iRst,
  lsu_ctrl_if.slave  bus
);

  tLsuState        state_q, state_d;
  logic            ready_q, ready_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;
  logic            is_load_q, is_load_d;
  tMemSize         funct3_q, funct3_d;
  logic [1:0]      lsb_q, lsb_d;
  logic [4:0]      rd_q, rd_d;

  logic            accept;
  logic            misaligned;
  logic [XLEN-1:0] store_lanes;
  logic [XLEN-1:0] load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 256) ? $clog2(TIMEOUT_CYC) : 8;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  assign accept = bus.iValid && ready_q &&
                  ((bus.iOpcode == eOpLoad) || (bus.iOpcode == eOpStore));

  // Unsupported sizes are reported the same way as misaligned ones
  always_comb begin
    case (bus.iFunct3)
      cF3Lb, cF3Lbu: misaligned = 1'b0;
      cF3Lh, cF3Lhu: misaligned = bus.iAddr[0];
      cF3Lw:         misaligned = |bus.iAddr[1:0];
      default:       misaligned = 1'b1;
    endcase

    case (bus.iFunct3[1:0])
      2'b00:   store_lanes = {4{bus.iStoreData[7:0]}};
      2'b01:   store_lanes = {2{bus.iStoreData[15:0]}};
      default: store_lanes = bus.iStoreData;
    endcase
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .iWord    (bus.iMemRData),
    .iFunct3  (funct3_q),
    .iAddrLsb (lsb_q),
    .oData    (load_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    lsb_d       = lsb_q;
    rd_d        = rd_q;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_load_d = (bus.iOpcode == eOpLoad);
          funct3_d  = bus.iFunct3;
          lsb_d     = bus.iAddr[1:0];
          rd_d      = bus.iRdAddr;
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = (bus.iOpcode == eOpStore);
            mem_addr_d  = {bus.iAddr[XLEN-1:2], 2'b00};
            mem_be_d    = fByteEn(bus.iFunct3[1:0], bus.iAddr[1:0]);
            mem_wdata_d = (bus.iOpcode == eOpStore) ? store_lanes : '0;
          end
        end
      end
      REQ: begin
        if (bus.iMemGnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          state_d     = is_load_q ? WAIT_RD : IDLE;
`ifdef LSU_TIMEOUT_EN
          tmo_cnt_d   = TMO_LOAD;
`endif
        end
      end
      WAIT_RD: begin
        if (bus.iMemRValid) begin
          wb_data_d  = load_data;
          wb_valid_d = (rd_q != 5'd0);
          state_d    = WB;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
`endif
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      is_load_q   <= 1'b0;
      funct3_q    <= '0;
      lsb_q       <= '0;
      rd_q        <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      lsb_q       <= lsb_d;
      rd_q        <= rd_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.oReady    = ready_q;
  assign bus.oMemReq   = mem_req_q;
  assign bus.oMemWe    = mem_we_q;
  assign bus.oMemAddr  = mem_addr_q;
  assign bus.oMemBe    = mem_be_q;
  assign bus.oMemWData = mem_wdata_q;
  assign bus.oWbValid  = wb_valid_q;
  assign bus.oWbRdAddr = rd_q;
  assign bus.oWbData   = wb_data_q;
  assign bus.oMisalign = misalign_q;
  assign bus.oBusy     = (state_q != IDLE);
`ifdef LSU_TIMEOUT_EN
  assign bus.oTimeout  = timeout_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with request/write-back scoreboards.
// The watchdog step is built only when LSU_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    tMemSize     f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] word;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
    int          stall;
    logic        spurious;
  } ld_vec_t;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  req_t req_q[$];
  wb_t  wb_q[$];

  always #5 iClk = ~iClk;

  lsu_ctrl_if bus ();

`ifdef LSU_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 64;
  lsu_ctrl #(.XLEN(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
`else
  lsu_ctrl #(.XLEN(32)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic issue(input tOpcode op, input tMemSize f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd);
    bus.iValid     = 1'b1;
    bus.iOpcode    = op;
    bus.iFunct3    = f3;
    bus.iAddr      = addr;
    bus.iStoreData = sdata;
    bus.iRdAddr    = rd;
    tick();
    bus.iValid     = 1'b0;
    bus.iOpcode    = eOpNone;
  endtask

  task automatic do_store(input tMemSize f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int stall);
    push_req(1'b1, exp_addr, exp_be, exp_wdata);
    issue(eOpStore, f3, addr, sdata, 5'd0);
    chkb("st_req_up", bus.oMemReq, 1'b1);
    chkb("st_ready_low", bus.oReady, 1'b0);
    repeat (stall) tick();
    bus.iMemGnt = 1'b1;
    tick();
    bus.iMemGnt = 1'b0;
    chkb("st_ready_back", bus.oReady, 1'b1);
    chkb("st_req_down", bus.oMemReq, 1'b0);
  endtask

  task automatic do_load(input ld_vec_t v);
    wb_t w;
    push_req(1'b0, v.exp_addr, v.exp_be, 32'h0);
    if (v.rd != 5'd0) begin
      w.rd = v.rd; w.data = v.exp_data;
      wb_q.push_back(w);
    end
    issue(eOpLoad, v.f3, v.addr, 32'h0, v.rd);
    chkb("ld_req_up", bus.oMemReq, 1'b1);
    repeat (v.stall) tick();
    bus.iMemGnt = 1'b1;
    if (v.spurious) begin
      bus.iMemRValid = 1'b1;
      bus.iMemRData  = ~v.word;
    end
    tick();
    bus.iMemGnt    = 1'b0;
    bus.iMemRValid = 1'b1;
    bus.iMemRData  = v.word;
    tick();
    bus.iMemRValid = 1'b0;
    bus.iMemRData  = 32'h0;
    chkb("ld_wb_valid", bus.oWbValid, v.rd != 5'd0);
    chkb("ld_ready_low", bus.oReady, 1'b0);
    tick();
    chkb("ld_wb_pulse_end", bus.oWbValid, 1'b0);
    chkb("ld_ready_back", bus.oReady, 1'b1);
  endtask

  // Scoreboard side: every cycle a request is up it must match the queue head
  always @(negedge iClk) begin
    if (iRst) begin
      if (bus.oMemReq) begin
        if (req_q.size() == 0) begin
          chkb("req_unexpected", bus.oMemReq, 1'b0);
        end else begin
          chkb("req_we", bus.oMemWe, req_q[0].we);
          chk("req_addr", bus.oMemAddr, req_q[0].addr);
          chk("req_be", 32'(bus.oMemBe), 32'(req_q[0].be));
          chk("req_wdata", bus.oMemWData, req_q[0].wdata);
          if (bus.iMemGnt) void'(req_q.pop_front());
        end
      end
      if (bus.oWbValid) begin
        if (wb_q.size() == 0) begin
          chkb("wb_unexpected", bus.oWbValid, 1'b0);
        end else begin
          chk("wb_rd", 32'(bus.oWbRdAddr), 32'(wb_q[0].rd));
          chk("wb_data", bus.oWbData, wb_q[0].data);
          void'(wb_q.pop_front());
        end
      end
    end
  end

  ld_vec_t lds[6];

  initial begin
    bus.iValid     = 1'b0;
    bus.iOpcode    = eOpNone;
    bus.iFunct3    = cF3Lb;
    bus.iAddr      = 32'h0;
    bus.iStoreData = 32'h0;
    bus.iRdAddr    = 5'd0;
    bus.iMemGnt    = 1'b0;
    bus.iMemRValid = 1'b0;
    bus.iMemRData  = 32'h0;

    lds[0] = '{cF3Lb,  32'h103, 5'd5,  32'h80FF_0000, 32'h100, 4'b1000, 32'hFFFF_FF80, 0, 1'b0};
    lds[1] = '{cF3Lhu, 32'h202, 5'd7,  32'hBEEF_1234, 32'h200, 4'b1100, 32'h0000_BEEF, 0, 1'b1};
    lds[2] = '{cF3Lh,  32'h202, 5'd8,  32'hBEEF_1234, 32'h200, 4'b1100, 32'hFFFF_BEEF, 1, 1'b0};
    lds[3] = '{cF3Lbu, 32'h101, 5'd9,  32'h1234_5678, 32'h100, 4'b0010, 32'h0000_0056, 0, 1'b1};
    lds[4] = '{cF3Lw,  32'h104, 5'd31, 32'hCAFE_F00D, 32'h104, 4'b1111, 32'hCAFE_F00D, 2, 1'b0};
    lds[5] = '{cF3Lh,  32'h100, 5'd2,  32'h1234_7FFF, 32'h100, 4'b0011, 32'h0000_7FFF, 0, 1'b0};

    // Reset values
    repeat (3) @(negedge iClk);
    chkb("rst_ready", bus.oReady, 1'b0);
    chkb("rst_req", bus.oMemReq, 1'b0);
    chkb("rst_busy", bus.oBusy, 1'b0);
    chkb("rst_wb_valid", bus.oWbValid, 1'b0);
    chkb("rst_misalign", bus.oMisalign, 1'b0);
    chk("rst_addr", bus.oMemAddr, 32'h0);
    iRst = 1'b1;
    tick();
    chkb("post_rst_ready", bus.oReady, 1'b1);

    // Stores: word, then a halfword store under a 5-cycle grant stall
    do_store(cF3Lw, 32'h100, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'hDEAD_BEEF, 0);
    do_store(cF3Lh, 32'h302, 32'h1234_BEEF, 32'h300, 4'b1100, 32'hBEEF_BEEF, 5);

    for (int i = 0; i < 6; i++) do_load(lds[i]);

    // Misaligned word load, next op accepted in the very next cycle
    issue(eOpLoad, cF3Lw, 32'h101, 32'h0, 5'd9);
    chkb("mis_pulse", bus.oMisalign, 1'b1);
    chkb("mis_ready", bus.oReady, 1'b1);
    chkb("mis_noreq", bus.oMemReq, 1'b0);
    push_req(1'b1, 32'h100, 4'b0100, 32'hA5A5_A5A5);
    issue(eOpStore, cF3Lb, 32'h102, 32'h0000_00A5, 5'd0);
    chkb("mis_pulse_end", bus.oMisalign, 1'b0);
    chkb("b2b_req", bus.oMemReq, 1'b1);
    bus.iMemGnt = 1'b1;
    tick();
    bus.iMemGnt = 1'b0;
    chkb("b2b_ready", bus.oReady, 1'b1);

    issue(eOpLoad, 3'b011, 32'h0, 32'h0, 5'd4);
    chkb("unsup_f3_mis", bus.oMisalign, 1'b1);
    tick();
    issue(eOpStore, cF3Lh, 32'h103, 32'h0, 5'd0);
    chkb("sh_mis", bus.oMisalign, 1'b1);
    tick();
    chkb("sh_mis_end", bus.oMisalign, 1'b0);

    // Word load to x0 with stalled grant: read happens, no write-back
    begin
      ld_vec_t z;
      z = '{cF3Lw, 32'h300, 5'd0, 32'h1122_3344, 32'h300, 4'b1111, 32'h1122_3344, 5, 1'b0};
      do_load(z);
    end

    // Non-memory opcodes are not accepted
    bus.iValid = 1'b1;
    bus.iOpcode = tOpcode'(2'd3);
    tick();
    bus.iOpcode = eOpNone;
    tick();
    bus.iValid = 1'b0;
    chkb("badop_busy", bus.oBusy, 1'b0);
    chkb("badop_ready", bus.oReady, 1'b1);

    // Reset while waiting for read data, late rvalid afterwards
    push_req(1'b0, 32'h400, 4'b1111, 32'h0);
    issue(eOpLoad, cF3Lw, 32'h400, 32'h0, 5'd3);
    bus.iMemGnt = 1'b1;
    tick();
    bus.iMemGnt = 1'b0;
    chkb("wait_busy", bus.oBusy, 1'b1);
    #2 iRst = 1'b0;
    #1;
    chkb("mid_rst_busy", bus.oBusy, 1'b0);
    chkb("mid_rst_ready", bus.oReady, 1'b0);
    chkb("mid_rst_req", bus.oMemReq, 1'b0);
    chk("mid_rst_wb_data", bus.oWbData, 32'h0);
    chk("mid_rst_wb_rd", 32'(bus.oWbRdAddr), 32'h0);
    @(negedge iClk);
    iRst = 1'b1;
    tick();
    chkb("rel_ready", bus.oReady, 1'b1);
    bus.iMemRValid = 1'b1;
    bus.iMemRData  = 32'h5555_AAAA;
    tick();
    bus.iMemRValid = 1'b0;
    chkb("late_rvalid_wb", bus.oWbValid, 1'b0);
    chkb("late_rvalid_busy", bus.oBusy, 1'b0);
    tick();
    chkb("late_rvalid_wb2", bus.oWbValid, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int found;
      found = -1;
      push_req(1'b0, 32'h500, 4'b1111, 32'h0);
      issue(eOpLoad, cF3Lw, 32'h500, 32'h0, 5'd4);
      bus.iMemGnt = 1'b1;
      tick();
      bus.iMemGnt = 1'b0;
      for (int i = 1; i <= TIMEOUT_CYC + 4; i++) begin
        tick();
        if (bus.oTimeout && found < 0) found = i;
      end
      chk("timeout_cycle", 32'(found), 32'(TIMEOUT_CYC));
      chkb("timeout_ready", bus.oReady, 1'b1);
    end
`endif

    repeat (2) tick();
    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
